reorder_buffer_mc: RTL and testbench

REORDER_BUFFER_MC -- requirements
Module: reorder_buffer_mc

---
 rtl/reorder_buffer_mc.sv | 218 +++++++++++++++++++++
 tb/tb_reorder_buffer_mc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mc.sv
// Purpose: circular reorder buffer with multi-channel writeback, 2-wide in-order retire, flush on mispredict, halt on Ex.
// Latency: allocation/writeback visible one cycle after the edge; commit and lookup outputs are combinational.
// Backpressure: in_ready drops when full, flushing, halted or rdy_in low; retirement in the same cycle frees no slot.
module reorder_buffer_mc #(
    parameter int ROB_SIZE_BIT = 4,
    parameter int NUM_WB       = 2
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_done,
    input  logic [1:0]                     in_type,
    input  logic [4:0]                     in_rd,
    input  logic [31:0]                    in_value,
    input  logic [31:0]                    in_jump_addr,
    output logic [ROB_SIZE_BIT-1:0]        alloc_id,
    output logic [ROB_SIZE_BIT-1:0]        head_id,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*ROB_SIZE_BIT-1:0] wb_rob_id,
    input  logic [NUM_WB*32-1:0]           wb_value,
    output logic [1:0]                     commit_valid,
    output logic [9:0]                     commit_rd,
    output logic [63:0]                    commit_value,
    output logic [2*ROB_SIZE_BIT-1:0]      commit_rob_id,
    input  logic [2*ROB_SIZE_BIT-1:0]      q_id,
    output logic [1:0]                     q_ready,
    output logic [63:0]                    q_value,
    output logic                           flush,
    output logic [31:0]                    flush_pc,
    output logic                           halted,
    output logic [ROB_SIZE_BIT:0]          count,
    output logic [31:0]                    retired_count
);
    localparam int RB = ROB_SIZE_BIT;
    localparam int SIZE = 1 << RB;
    localparam logic [RB:0] FULL = SIZE[RB:0];
    localparam logic [1:0] T_RG = 2'd0, T_ST = 2'd1, T_BR = 2'd2, T_EX = 2'd3;

    logic [SIZE-1:0] busy_q, busy_d, done_q, done_d;
    logic [1:0]      type_q [SIZE];
    logic [1:0]      type_d [SIZE];
    logic [4:0]      rd_q   [SIZE];
    logic [4:0]      rd_d   [SIZE];
    logic [31:0]     value_q[SIZE];
    logic [31:0]     value_d[SIZE];
    logic [31:0]     jump_q [SIZE];
    logic [31:0]     jump_d [SIZE];
    logic [RB-1:0]   head_q, head_d, tail_q, tail_d, head1;
    logic [RB:0]     count_q, count_d;
    logic [31:0]     retired_q, retired_d, flush_pc_q, flush_pc_d;
    logic            flush_q, flush_d, halted_q, halted_d;
    logic            alloc, ret0, ret1, br_mis;
    logic [1:0]      n_ret;

    assign head1    = head_q + 1'b1;
    assign in_ready = (count_q != FULL) && !flush_q && !halted_q && rdy_in;
    assign alloc    = in_valid && in_ready;
    // Retirement looks only at stored done bits; the pipeline clear cycle retires nothing.
    assign ret0     = busy_q[head_q] && done_q[head_q] && rdy_in && !halted_q && !flush_q;
    assign ret1     = ret0 && (type_q[head_q] == T_RG || type_q[head_q] == T_ST)
                      && busy_q[head1] && done_q[head1];
    assign n_ret    = {1'b0, ret0} + {1'b0, ret1};
    assign br_mis   = ret0 && (type_q[head_q] == T_BR)
                      && (value_q[head_q][0] != jump_q[head_q][0]);

    assign alloc_id      = tail_q;
    assign head_id       = head_q;
    assign flush         = flush_q;
    assign flush_pc      = flush_pc_q;
    assign halted        = halted_q;
    assign count         = count_q;
    assign retired_count = retired_q;

    // Commit slots are zeroed when not retiring so idle outputs stay quiet.
    always_comb begin
        commit_valid  = {ret1, ret0};
        commit_rd     = '0;
        commit_value  = '0;
        commit_rob_id = '0;
        if (ret0) begin
            commit_rd[4:0]      = (type_q[head_q] == T_RG) ? rd_q[head_q] : 5'd0;
            commit_value[31:0]  = value_q[head_q];
            commit_rob_id[RB-1:0] = head_q;
        end
        if (ret1) begin
            commit_rd[9:5]      = (type_q[head1] == T_RG) ? rd_q[head1] : 5'd0;
            commit_value[63:32] = value_q[head1];
            commit_rob_id[2*RB-1:RB] = head1;
        end
    end

    // Operand lookup: stored value first, else the highest-index writeback hitting the entry.
    always_comb begin
        q_ready = '0;
        q_value = '0;
        for (int s = 0; s < 2; s++) begin
            if (done_q[q_id[s*RB +: RB]]) begin
                q_ready[s]          = 1'b1;
                q_value[s*32 +: 32] = value_q[q_id[s*RB +: RB]];
            end else begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && wb_rob_id[k*RB +: RB] == q_id[s*RB +: RB]) begin
                        q_ready[s]          = 1'b1;
                        q_value[s*32 +: 32] = wb_value[k*32 +: 32];
                    end
                end
            end
        end
    end

    // Next state: flush clear, else writeback, retire-clear, then allocate (allocation wins an index clash).
    always_comb begin
        busy_d     = busy_q;
        done_d     = done_q;
        type_d     = type_q;
        rd_d       = rd_q;
        value_d    = value_q;
        jump_d     = jump_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        retired_d  = retired_q;
        flush_d    = flush_q;
        flush_pc_d = flush_pc_q;
        halted_d   = halted_q;
        if (rdy_in) begin
            if (flush_q) begin
                busy_d  = '0;
                done_d  = '0;
                for (int i = 0; i < SIZE; i++) begin
                    type_d[i]  = '0;
                    rd_d[i]    = '0;
                    value_d[i] = '0;
                    jump_d[i]  = '0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                flush_d = 1'b0;
            end else begin
                for (int k = 0; k < NUM_WB; k++) begin
                    if (wb_valid[k] && busy_q[wb_rob_id[k*RB +: RB]]) begin
                        done_d[wb_rob_id[k*RB +: RB]]  = 1'b1;
                        value_d[wb_rob_id[k*RB +: RB]] = wb_value[k*32 +: 32];
                    end
                end
                if (ret0) begin
                    busy_d[head_q]  = 1'b0;
                    done_d[head_q]  = 1'b0;
                    type_d[head_q]  = '0;
                    rd_d[head_q]    = '0;
                    value_d[head_q] = '0;
                    jump_d[head_q]  = '0;
                end
                if (ret1) begin
                    busy_d[head1]  = 1'b0;
                    done_d[head1]  = 1'b0;
                    type_d[head1]  = '0;
                    rd_d[head1]    = '0;
                    value_d[head1] = '0;
                    jump_d[head1]  = '0;
                end
                if (alloc) begin
                    busy_d[tail_q]  = 1'b1;
                    done_d[tail_q]  = in_done;
                    type_d[tail_q]  = in_type;
                    rd_d[tail_q]    = in_rd;
                    value_d[tail_q] = in_value;
                    jump_d[tail_q]  = in_jump_addr;
                end
                head_d    = head_q + RB'(n_ret);
                tail_d    = tail_q + RB'(alloc);
                count_d   = count_q + (RB+1)'(alloc) - (RB+1)'(n_ret);
                retired_d = retired_q + 32'(n_ret);
                flush_d   = br_mis;
                if (br_mis) flush_pc_d = {jump_q[head_q][31:1], 1'b0};
                if (ret0 && type_q[head_q] == T_EX) halted_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                type_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
                jump_q[i]  <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            retired_q  <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            type_q     <= type_d;
            rd_q       <= rd_d;
            value_q    <= value_d;
            jump_q     <= jump_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            retired_q  <= retired_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
            halted_q   <= halted_d;
        end
    end
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Purpose: directed scenario bench for reorder_buffer_mc.
// Latency: inputs driven 1ns after posedge, outputs sampled 2ns after posedge.
// Backpressure: in_ready checked directly in the full, flush and halt scenarios.
module tb_reorder_buffer_mc;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, in_valid, in_ready, in_done;
    logic [1:0]  in_type;
    logic [4:0]  in_rd;
    logic [31:0] in_value, in_jump_addr;
    logic [3:0]  alloc_id, head_id;
    logic [1:0]  wb_valid;
    logic [7:0]  wb_rob_id;
    logic [63:0] wb_value;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [63:0] commit_value;
    logic [7:0]  commit_rob_id;
    logic [7:0]  q_id;
    logic [1:0]  q_ready;
    logic [63:0] q_value;
    logic        flush, halted;
    logic [31:0] flush_pc, retired_count;
    logic [4:0]  count;
    int total = 0;
    int bad   = 0;

    reorder_buffer_mc #(.ROB_SIZE_BIT(4), .NUM_WB(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_done(in_done),
        .in_type(in_type), .in_rd(in_rd), .in_value(in_value), .in_jump_addr(in_jump_addr),
        .alloc_id(alloc_id), .head_id(head_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_rob_id(commit_rob_id), .q_id(q_id), .q_ready(q_ready), .q_value(q_value),
        .flush(flush), .flush_pc(flush_pc), .halted(halted), .count(count),
        .retired_count(retired_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clr_in();
        in_valid = 0; in_done = 0; in_type = 0; in_rd = 0; in_value = 0; in_jump_addr = 0;
        wb_valid = 0; wb_rob_id = 0; wb_value = 0; rdy_in = 1;
    endtask

    task automatic do_reset();
        clr_in(); q_id = 0; rst_in = 1;
        tick(); tick();
        rst_in = 0;
    endtask

    task automatic drive_alloc(input logic [1:0] t, input logic [4:0] rd,
                               input logic [31:0] v, input logic [31:0] j, input logic d);
        in_valid = 1; in_type = t; in_rd = rd; in_value = v; in_jump_addr = j; in_done = d;
    endtask

    // Fill all 16 entries as Rg; entry 0 stays not-done so nothing retires meanwhile.
    task automatic fill_rob();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(2'd0, 5'(i + 1), 32'(100 + i), 32'd0, i != 0);
            tick();
        end
        clr_in();
    endtask

    task automatic test_reset();
        clr_in(); q_id = 0; rst_in = 1;
        tick(); tick();
        #1;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        total++; if (head_id !== 4'd0 || alloc_id !== 4'd0) begin bad++; $display("FAIL reset_ptrs got %0d/%0d want 0/0", head_id, alloc_id); end
        total++; if (flush !== 1'b0 || halted !== 1'b0 || flush_pc !== 32'd0) begin bad++; $display("FAIL reset_flags got %b%b %h want 00 0", flush, halted, flush_pc); end
        total++; if (retired_count !== 32'd0 || commit_valid !== 2'b00) begin bad++; $display("FAIL reset_retire got %0d %b want 0 00", retired_count, commit_valid); end
        rst_in = 0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fill_drain();
        logic [9:0]  exp_rd;
        logic [63:0] exp_val;
        logic [7:0]  exp_id;
        do_reset();
        fill_rob();
        #1;
        total++; if (count !== 5'd16 || in_ready !== 1'b0) begin bad++; $display("FAIL fill_full got %0d %b want 16 0", count, in_ready); end
        wb_valid = 2'b01; wb_rob_id = 8'h00; wb_value = {32'd0, 32'h77};
        #1;
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL fill_no_retire got %b want 00", commit_valid); end
        tick(); clr_in();
        for (int c = 0; c < 8; c++) begin
            exp_rd  = {5'(2*c + 2), 5'(2*c + 1)};
            exp_val = {32'(100 + 2*c + 1), (c == 0) ? 32'h77 : 32'(100 + 2*c)};
            exp_id  = {4'(2*c + 1), 4'(2*c)};
            #1;
            total++; if (commit_valid !== 2'b11) begin bad++; $display("FAIL drain_valid c=%0d got %b want 11", c, commit_valid); end
            total++; if (commit_rd !== exp_rd || commit_value !== exp_val || commit_rob_id !== exp_id)
                begin bad++; $display("FAIL drain_data c=%0d got %h %h %h want %h %h %h", c, commit_rd, commit_value, commit_rob_id, exp_rd, exp_val, exp_id); end
            tick();
        end
        total++; if (retired_count !== 32'd16 || count !== 5'd0) begin bad++; $display("FAIL drain_done got %0d %0d want 16 0", retired_count, count); end
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL drain_idle got %b want 00", commit_valid); end
    endtask

    task automatic test_full_same_cycle();
        do_reset();
        fill_rob();
        wb_valid = 2'b01; wb_rob_id = 8'h00; wb_value = {32'd0, 32'h5};
        tick(); clr_in();
        drive_alloc(2'd0, 5'd30, 32'hDEAD, 32'd0, 1'b1);
        #1;
        total++; if (in_ready !== 1'b0 || commit_valid !== 2'b11) begin bad++; $display("FAIL full_same got %b %b want 0 11", in_ready, commit_valid); end
        tick(); clr_in();
        total++; if (count !== 5'd14 || alloc_id !== 4'd0) begin bad++; $display("FAIL full_count got %0d %0d want 14 0", count, alloc_id); end
    endtask

    task automatic test_wb_order();
        do_reset();
        drive_alloc(2'd0, 5'd5, 32'd0, 32'd0, 1'b0); tick();
        drive_alloc(2'd0, 5'd6, 32'd0, 32'd0, 1'b0); tick();
        clr_in();
        wb_valid = 2'b01; wb_rob_id = 8'h01; wb_value = {32'd0, 32'h11};
        #1;
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb1_hold got %b want 00", commit_valid); end
        tick(); clr_in();
        wb_valid = 2'b10; wb_rob_id = 8'h00; wb_value = {32'h10, 32'd0};
        #1;
        total++; if (commit_valid !== 2'b00) begin bad++; $display("FAIL wb0_hold got %b want 00", commit_valid); end
        tick(); clr_in();
        #1;
        total++; if (commit_valid !== 2'b11 || commit_rd !== {5'd6, 5'd5}) begin bad++; $display("FAIL wb_pair got %b %h want 11 %h", commit_valid, commit_rd, {5'd6, 5'd5}); end
        total++; if (commit_value !== {32'h11, 32'h10}) begin bad++; $display("FAIL wb_pair_val got %h want %h", commit_value, {32'h11, 32'h10}); end
        tick();
        total++; if (count !== 5'd0 || retired_count !== 32'd2) begin bad++; $display("FAIL wb_after got %0d %0d want 0 2", count, retired_count); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive_alloc(2'd2, 5'd0, 32'd0, 32'h1000, 1'b0); tick();
        drive_alloc(2'd0, 5'd3, 32'h33, 32'd0, 1'b1); tick();
        clr_in();
        wb_valid = 2'b10; wb_rob_id = 8'h00; wb_value = {32'h1, 32'd0};
        tick(); clr_in();
        #1;
        total++; if (commit_valid !== 2'b01 || commit_rd !== 10'd0) begin bad++; $display("FAIL br_alone got %b %h want 01 000", commit_valid, commit_rd); end
        tick();
        drive_alloc(2'd0, 5'd9, 32'h99, 32'd0, 1'b1);
        #1;
        total++; if (flush !== 1'b1 || flush_pc !== 32'h1000) begin bad++; $display("FAIL br_flush got %b %h want 1 00001000", flush, flush_pc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL br_ready got %b want 0", in_ready); end
        tick(); clr_in();
        total++; if (flush !== 1'b0 || count !== 5'd0) begin bad++; $display("FAIL br_clear got %b %0d want 0 0", flush, count); end
        total++; if (head_id !== 4'd0 || alloc_id !== 4'd0 || retired_count !== 32'd1) begin bad++; $display("FAIL br_ptrs got %0d %0d %0d want 0 0 1", head_id, alloc_id, retired_count); end
    endtask

    task automatic test_wb_same_id();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(2'd0, 5'(i), 32'd0, 32'd0, 1'b0);
            tick();
        end
        clr_in();
        wb_valid = 2'b11; wb_rob_id = {4'd3, 4'd3}; wb_value = {32'hB, 32'hA}; q_id = {4'd2, 4'd3};
        #1;
        total++; if (q_ready !== 2'b01 || q_value[31:0] !== 32'hB) begin bad++; $display("FAIL wbsame_bypass got %b %h want 01 0000000b", q_ready, q_value[31:0]); end
        tick(); clr_in();
        wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd3}; wb_value = {32'd0, 32'hC};
        #1;
        total++; if (q_ready !== 2'b01 || q_value[31:0] !== 32'hB) begin bad++; $display("FAIL wbsame_stored got %b %h want 01 0000000b", q_ready, q_value[31:0]); end
        tick(); clr_in();
        wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd9}; wb_value = {32'd0, 32'h55};
        tick(); clr_in();
        q_id = {4'd9, 4'd3};
        #1;
        total++; if (q_ready !== 2'b01 || q_value[31:0] !== 32'hC) begin bad++; $display("FAIL wb_nonbusy got %b %h want 01 0000000c", q_ready, q_value[31:0]); end
        q_id = 0;
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        drive_alloc(2'd0, 5'd7, 32'h42, 32'd0, 1'b1); tick();
        clr_in();
        rdy_in = 0;
        #1;
        total++; if (commit_valid !== 2'b00 || in_ready !== 1'b0) begin bad++; $display("FAIL freeze_out got %b %b want 00 0", commit_valid, in_ready); end
        tick();
        total++; if (count !== 5'd1 || retired_count !== 32'd0) begin bad++; $display("FAIL freeze_hold got %0d %0d want 1 0", count, retired_count); end
        rdy_in = 1;
        #1;
        total++; if (commit_valid !== 2'b01 || commit_value[31:0] !== 32'h42) begin bad++; $display("FAIL freeze_resume got %b %h want 01 00000042", commit_valid, commit_value[31:0]); end
        tick();
        total++; if (count !== 5'd0 || retired_count !== 32'd1) begin bad++; $display("FAIL freeze_after got %0d %0d want 0 1", count, retired_count); end
    endtask

    task automatic test_halt_reset();
        do_reset();
        drive_alloc(2'd3, 5'd0, 32'hE, 32'd0, 1'b1); tick();
        drive_alloc(2'd0, 5'd4, 32'h44, 32'd0, 1'b1);
        #1;
        total++; if (commit_valid !== 2'b01) begin bad++; $display("FAIL ex_retire got %b want 01", commit_valid); end
        tick(); clr_in();
        #1;
        total++; if (halted !== 1'b1 || in_ready !== 1'b0 || commit_valid !== 2'b00) begin bad++; $display("FAIL halt_state got %b %b %b want 1 0 00", halted, in_ready, commit_valid); end
        tick();
        total++; if (commit_valid !== 2'b00 || retired_count !== 32'd1) begin bad++; $display("FAIL halt_sticky got %b %0d want 00 1", commit_valid, retired_count); end
        tick();
        rst_in = 1;
        tick();
        rst_in = 0;
        #1;
        total++; if (halted !== 1'b0 || count !== 5'd0 || retired_count !== 32'd0) begin bad++; $display("FAIL halt_rst got %b %0d %0d want 0 0 0", halted, count, retired_count); end
        total++; if (commit_valid !== 2'b00 || commit_value !== 64'd0 || q_ready !== 2'b00 || flush !== 1'b0 || head_id !== 4'd0 || alloc_id !== 4'd0)
            begin bad++; $display("FAIL halt_rst_out got %b %h %b %b %0d %0d want all zero", commit_valid, commit_value, q_ready, flush, head_id, alloc_id); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_same_cycle();
        test_wb_order();
        test_branch_flush();
        test_wb_same_id();
        test_rdy_freeze();
        test_halt_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
